// File: rtl/uart_pkg.sv
// Shared UART types and constants, used by uart_rx and uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input that idles high;
// both stages reset to the idle level.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= UART_IDLE_LEVEL;
            sync_q <= UART_IDLE_LEVEL;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
        end
    end

    assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready output, framing-error and overrun pulses.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx
    import uart_pkg::*;
#(
    parameter int clk_freq_hz = 100000000,
    parameter int baud_rate   = 115200
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_uart_rx,
    output logic [UART_DATA_BITS-1:0] o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_frame_err,
    output logic                      o_overrun
);

    localparam int BIT_CYCLES  = clk_freq_hz / baud_rate;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CNT_W       = $clog2(BIT_CYCLES) + 1;
    localparam int IDX_W       = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(UART_DATA_BITS - 1);

    if (BIT_CYCLES < 4) begin : gBitCyclesCheck
        $fatal(1, "uart_rx: clk_freq_hz/baud_rate must be at least 4");
    end

    uart_rx_state_t            state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [IDX_W-1:0]          bitIdx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] shift_d;
    logic [UART_DATA_BITS-1:0] data_q;
    logic                      valid_q;
    logic                      frameErr_q;
    logic                      overrun_q;
    logic                      rxSync;
    logic                      active;
    logic                      cntZero;
    logic                      sampleEvent;
    logic                      sampleBit;

    uart_rx_sync uSync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_uart_rx),
        .o_sync  (rxSync)
    );

    assign active  = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    assign cntZero = (cnt_q == '0);
    assign shift_d = {sampleBit, shift_q[UART_DATA_BITS-1:1]};

`ifdef UART_RX_MAJORITY_EN
    // Votes over the samples taken one cycle before, at, and one cycle after
    // the bit centre; the decision lands a cycle late but the counter keeps
    // its original cadence, so only the frame end shifts.
    logic early_q;
    logic mid_q;
    logic evalPend_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            early_q    <= UART_IDLE_LEVEL;
            mid_q      <= UART_IDLE_LEVEL;
            evalPend_q <= 1'b0;
        end else begin
            if (cnt_q == CNT_W'(1)) begin
                early_q <= rxSync;
            end
            if (cntZero) begin
                mid_q <= rxSync;
            end
            evalPend_q <= active && cntZero;
        end
    end

    assign sampleEvent = evalPend_q;
    assign sampleBit   = (early_q & mid_q) | (early_q & rxSync) | (mid_q & rxSync);
`else
    assign sampleEvent = active && cntZero;
    assign sampleBit   = rxSync;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
            if (valid_q && i_ready) begin
                valid_q <= 1'b0;
            end
            if (active) begin
                cnt_q <= cntZero ? BIT_RELOAD : cnt_q - CNT_W'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (!rxSync) begin
                        cnt_q   <= HALF_RELOAD;
                        state_q <= START;
                    end
                end
                START: begin
                    if (sampleEvent) begin
                        if (sampleBit) begin
                            state_q <= IDLE;
                        end else begin
                            bitIdx_q <= '0;
                            state_q  <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (sampleEvent) begin
                        shift_q  <= shift_d;
                        bitIdx_q <= bitIdx_q + IDX_W'(1);
                        if (bitIdx_q == LAST_IDX) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    // Returning to IDLE right away lets a start bit that
                    // directly follows the stop bit be caught without a gap.
                    if (sampleEvent) begin
                        if (sampleBit) begin
                            state_q <= IDLE;
                            if (!valid_q || i_ready) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frameErr_q <= 1'b1;
                            state_q    <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxSync) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frameErr_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 1 MHz / 100 kbaud (10 clocks per bit).
// Build with UART_RX_MAJORITY_EN to exercise the majority-sampling variant.
module tb_uart_rx;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int BIT    = CLK_HZ / BAUD;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT_NOM = 2 + BIT / 2 + 9 * BIT + 1 + 1;
`else
    localparam int LAT_NOM = 2 + BIT / 2 + 9 * BIT + 1;
`endif

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         expBytes;
        int         expErrs;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       rxLine;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frameErr;
    logic       overrun;

    int         checks = 0;
    int         errors = 0;
    int         cycle = 0;
    logic [7:0] gotData[$];
    int         gotCycle[$];
    logic [7:0] expQ[$];
    int         errPulses;
    int         ovrPulses;
    int         validCycles;

    uart_rx #(
        .clk_freq_hz (CLK_HZ),
        .baud_rate   (BAUD)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_uart_rx   (rxLine),
        .o_data      (data),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_frame_err (frameErr),
        .o_overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Observes outputs on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) validCycles++;
            if (valid && ready) begin
                gotData.push_back(data);
                gotCycle.push_back(cycle);
            end
            if (frameErr) errPulses++;
            if (overrun) ovrPulses++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, required to have finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxLine = 1'b1;
        repeat (n) tick();
    endtask

    task automatic clearEvents();
        gotData.delete();
        gotCycle.delete();
        errPulses   = 0;
        ovrPulses   = 0;
        validCycles = 0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Drives one frame; a non-negative glitchBit flips that data bit for one
    // cycle at the receiver's nominal sampling point. Line is left at stopBit.
    task automatic sendFrame(input logic [7:0] b, input logic stopBit, input int glitchBit,
                             output int startCycle);
        rxLine     = 1'b0;
        startCycle = cycle;
        repeat (BIT) tick();
        for (int i = 0; i < 8; i++) begin
            for (int t = 0; t < BIT; t++) begin
                rxLine = (i == glitchBit && t == BIT / 2) ? ~b[i] : b[i];
                tick();
            end
        end
        rxLine = stopBit;
        repeat (BIT) tick();
    endtask

    task automatic applyStimulus(input vec_t v);
        int t0;
        clearEvents();
        sendFrame(v.data, v.stopBit, -1, t0);
        if (!v.stopBit) repeat (40) tick();
        idle(30);
    endtask

    initial begin
        vec_t       vecs[8];
        int         t0;
        int         t1;
        logic [7:0] b;
        logic       good;
        int         gap;
        int         expErrs;

        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 0};
        vecs[3] = '{8'h81, 1'b0, 0, 1};
        vecs[4] = '{8'h5A, 1'b1, 1, 0};
        vecs[5] = '{8'h01, 1'b1, 1, 0};
        vecs[6] = '{8'h80, 1'b1, 1, 0};
        vecs[7] = '{8'h00, 1'b0, 0, 1};

        rst    = 1'b1;
        rxLine = 1'b1;
        ready  = 1'b1;
        clearEvents();
        tick();
        checkOutput("reset valid", valid, 0);
        checkOutput("reset data", data, 0);
        checkOutput("reset frame_err", frameErr, 0);
        checkOutput("reset overrun", overrun, 0);
        repeat (2) tick();
        rst = 1'b0;
        idle(10);

        // Single frame: value, one-cycle valid, latency from the start edge.
        clearEvents();
        sendFrame(8'hA5, 1'b1, -1, t0);
        idle(20);
        checkOutput("single beats", gotData.size(), 1);
        if (gotData.size() > 0) begin
            checkOutput("single data", gotData[0], 8'hA5);
            checkRange("single latency", gotCycle[0] - t0, LAT_NOM - 1, LAT_NOM + 1);
        end
        checkOutput("single valid width", validCycles, 1);
        checkOutput("single frame_err", errPulses, 0);
        checkOutput("single overrun", ovrPulses, 0);

        // Back-to-back frames with no idle gap.
        clearEvents();
        sendFrame(8'h00, 1'b1, -1, t0);
        sendFrame(8'hFF, 1'b1, -1, t1);
        sendFrame(8'h3C, 1'b1, -1, t1);
        idle(20);
        checkOutput("b2b beats", gotData.size(), 3);
        if (gotData.size() == 3) begin
            checkOutput("b2b data0", gotData[0], 8'h00);
            checkOutput("b2b data1", gotData[1], 8'hFF);
            checkOutput("b2b data2", gotData[2], 8'h3C);
            checkOutput("b2b spacing01", gotCycle[1] - gotCycle[0], 100);
            checkOutput("b2b spacing12", gotCycle[2] - gotCycle[1], 100);
        end

        // Short low glitch is a false start, then a real frame.
        clearEvents();
        rxLine = 1'b0;
        repeat (3) tick();
        idle(30);
        checkOutput("glitch no beat", gotData.size(), 0);
        checkOutput("glitch no error", errPulses, 0);
        sendFrame(8'h5A, 1'b1, -1, t0);
        idle(20);
        checkOutput("after glitch beats", gotData.size(), 1);
        if (gotData.size() > 0) checkOutput("after glitch data", gotData[0], 8'h5A);

        // Framing error with the line held low afterwards.
        clearEvents();
        sendFrame(8'h81, 1'b0, -1, t0);
        repeat (40) tick();
        idle(20);
        checkOutput("ferr pulses", errPulses, 1);
        checkOutput("ferr no beat", gotData.size(), 0);
        sendFrame(8'h42, 1'b1, -1, t0);
        idle(20);
        checkOutput("after ferr beats", gotData.size(), 1);
        if (gotData.size() > 0) checkOutput("after ferr data", gotData[0], 8'h42);
        checkOutput("after ferr pulses", errPulses, 1);

        // Overrun: consumer stalled across two frames.
        ready = 1'b0;
        clearEvents();
        sendFrame(8'h11, 1'b1, -1, t0);
        sendFrame(8'h22, 1'b1, -1, t0);
        idle(20);
        checkOutput("ovr valid held", valid, 1);
        checkOutput("ovr data held", data, 8'h11);
        checkOutput("ovr pulses", ovrPulses, 1);
        ready = 1'b1;
        tick();
        tick();
        checkOutput("ovr drained valid", valid, 0);
        checkOutput("ovr drained beats", gotData.size(), 1);
        if (gotData.size() > 0) checkOutput("ovr drained data", gotData[0], 8'h11);

        // Reset in the middle of a frame while a byte is still held.
        ready = 1'b0;
        clearEvents();
        sendFrame(8'h33, 1'b1, -1, t0);
        idle(20);
        checkOutput("pre-reset valid", valid, 1);
        b      = 8'h77;
        rxLine = 1'b0;
        repeat (BIT) tick();
        for (int i = 0; i < 3; i++) begin
            rxLine = b[i];
            repeat (BIT) tick();
        end
        rst = 1'b1;
        tick();
        checkOutput("midreset valid", valid, 0);
        checkOutput("midreset data", data, 0);
        checkOutput("midreset frame_err", frameErr, 0);
        checkOutput("midreset overrun", overrun, 0);
        rst    = 1'b0;
        ready  = 1'b1;
        idle(150);
        clearEvents();
        sendFrame(8'h99, 1'b1, -1, t0);
        idle(20);
        checkOutput("post-reset beats", gotData.size(), 1);
        if (gotData.size() > 0) checkOutput("post-reset data", gotData[0], 8'h99);
        checkOutput("post-reset frame_err", errPulses, 0);

`ifdef UART_RX_MAJORITY_EN
        // Single-cycle glitch on a data bit centre must be voted out.
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom_range(0, 255));
            clearEvents();
            sendFrame(b, 1'b1, int'($urandom_range(0, 7)), t0);
            idle(20);
            checkOutput("majority beats", gotData.size(), 1);
            if (gotData.size() > 0) checkOutput("majority data", gotData[0], b);
        end
`endif

        // Table of single-frame vectors.
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v]);
            checkOutput("table beats", gotData.size(), vecs[v].expBytes);
            checkOutput("table frame_err", errPulses, vecs[v].expErrs);
            checkOutput("table overrun", ovrPulses, 0);
            if (vecs[v].expBytes == 1 && gotData.size() > 0)
                checkOutput("table data", gotData[0], vecs[v].data);
        end

        // Random frames against a byte-queue reference model.
        clearEvents();
        expQ.delete();
        expErrs = 0;
        for (int n = 0; n < 40; n++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 7) != 0);
            sendFrame(b, good, -1, t0);
            if (good) begin
                expQ.push_back(b);
                gap = int'($urandom_range(0, 15));
            end else begin
                expErrs++;
                repeat ($urandom_range(0, 30)) tick();
                rxLine = 1'b1;
                gap    = int'($urandom_range(2, 15));
            end
            repeat (gap) tick();
        end
        idle(30);
        checkOutput("random beats", gotData.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < gotData.size(); i++)
            checkOutput("random byte", gotData[i], expQ[i]);
        checkOutput("random frame_err", errPulses, expErrs);
        checkOutput("random overrun", ovrPulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
